// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared state encoding, port indices and width helpers for the data-memory port arbiter
package dmem_arb_pkg;
  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;
  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;
  function automatic int line_w(input int block_size, input int line_size);
    return (2 ** block_size) * line_size;
  endfunction
  function automatic int addr_w(input int address_size, input int block_size);
    return address_size - block_size - 2;
  endfunction
endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: winner selection between ports I and D.
// Round-robin when DMEM_ARB_ROUND_ROBIN_EN is defined, otherwise fixed D-over-I priority.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic req_i,
  input  logic req_d,
  input  logic last_grant,
  output logic grant_d
);
`ifdef DMEM_ARB_ROUND_ROBIN_EN
  assign grant_d = req_d & (~req_i | (last_grant == PORT_I));
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
  assign grant_d = req_d;
`endif
endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one block-wide data memory between I-cache and D-cache refill ports.
// Optional round-robin arbitration via DMEM_ARB_ROUND_ROBIN_EN (see dmem_arb_pick).
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int c_block_size = 2,
  parameter int c_line_size  = 32,
  parameter int address_size = 32,
  localparam int LINE_W = line_w(c_block_size, c_line_size),
  localparam int ADDR_W = addr_w(address_size, c_block_size)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_address,
  input  logic [LINE_W-1:0] i_writedata,
  output logic              i_busywait,
  output logic [LINE_W-1:0] i_readdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_writedata,
  output logic              d_busywait,
  output logic [LINE_W-1:0] d_readdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_writedata,
  input  logic              mem_busywait,
  input  logic [LINE_W-1:0] mem_readdata,
  input  logic              mem_read_done,
  input  logic              mem_write_done
);
  state_t state;
  logic last_grant, grant_d, req_i, req_d, done, gnt_i, gnt_d;
  logic unused_mem_busywait;
  assign unused_mem_busywait = mem_busywait;
  assign req_i = i_read | i_write;
  assign req_d = d_read | d_write;
  assign done  = mem_read_done | mem_write_done;
  assign gnt_i = state == GNT_I;
  assign gnt_d = state == GNT_D;
  dmem_arb_pick u_pick (
    .req_i      (req_i),
    .req_d      (req_d),
    .last_grant (last_grant),
    .grant_d    (grant_d)
  );
  // strobes are gated by reset so memory never sees a request while both sides reset
  assign mem_read      = reset & (gnt_i ? i_read : gnt_d & d_read);
  assign mem_write     = reset & (gnt_i ? i_write : gnt_d & d_write);
  assign mem_address   = gnt_i ? i_address : gnt_d ? d_address : '0;
  assign mem_writedata = gnt_i ? i_writedata : gnt_d ? d_writedata : '0;
  assign i_busywait    = req_i & ~(reset & gnt_i & done);
  assign d_busywait    = req_d & ~(reset & gnt_d & done);
  assign i_readdata    = mem_readdata;
  assign d_readdata    = mem_readdata;
  always_ff @(posedge clock)
    if (!reset) begin
      state      <= IDLE;
      last_grant <= PORT_D;
    end else if (state == IDLE) begin
      if (req_i | req_d) state <= grant_d ? GNT_D : GNT_I;
    end else if (done) begin
      state      <= IDLE;
      last_grant <= gnt_d ? PORT_D : PORT_I;
    end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed tests plus a per-cycle reference model of the two-port memory arbiter.
module tb_dmem_port_arbiter;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clock = 0, reset = 0;
  logic i_read = 0, i_write = 0, d_read = 0, d_write = 0;
  logic [27:0] i_address = '0, d_address = '0, mem_address;
  logic [127:0] i_writedata = '0, d_writedata = '0, i_readdata, d_readdata, mem_writedata;
  logic i_busywait, d_busywait, mem_read, mem_write;
  logic [127:0] mem_rdata_r = '0;
  logic auto_rd = 0, auto_wr = 0, stray_rd = 0, stray_wr = 0;
  logic mem_read_done, mem_write_done;
  int lat_cnt = 0;
  int asserts = 0, fails = 0;
  bit chk_on = 0;
  always #5 clock = ~clock;
  assign mem_read_done  = auto_rd | stray_rd;
  assign mem_write_done = auto_wr | stray_wr;

  dmem_port_arbiter dut (
    .clock(clock), .reset(reset),
    .i_read(i_read), .i_write(i_write), .i_address(i_address), .i_writedata(i_writedata),
    .i_busywait(i_busywait), .i_readdata(i_readdata),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_writedata(d_writedata),
    .d_busywait(d_busywait), .d_readdata(d_readdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_busywait(1'b0), .mem_readdata(mem_rdata_r),
    .mem_read_done(mem_read_done), .mem_write_done(mem_write_done)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // memory: answers a strobe with a one-cycle done pulse five cycles after it rises
  always @(posedge clock) begin
    auto_rd <= 0;
    auto_wr <= 0;
    if (!reset) lat_cnt <= 0;
    else if (lat_cnt == 0 && (mem_read | mem_write) && !auto_rd && !auto_wr) lat_cnt <= 1;
    else if (lat_cnt == 4) begin
      lat_cnt <= 0;
      auto_rd <= mem_read;
      auto_wr <= mem_write;
      mem_rdata_r <= {4{4'hA, mem_address}};
    end else if (lat_cnt > 0) lat_cnt <= lat_cnt + 1;
  end

  // reference model: owner is the port holding memory (-1 none, 0 I, 1 D)
  int owner = -1;
  int last = 1;
  wire ri = i_read | i_write, rd = d_read | d_write, done = mem_read_done | mem_write_done;
  always @(posedge clock)
    if (!reset) begin
      owner <= -1;
      last  <= 1;
    end else if (owner < 0) begin
      if (ri && rd) owner <= RR ? (last == 1 ? 0 : 1) : 1;
      else if (rd) owner <= 1;
      else if (ri) owner <= 0;
    end else if (done) begin
      last  <= owner;
      owner <= -1;
    end

  int served[$];
  bit seen_hi = 0, first_wr = 0, prev_hi = 0;
  int gap_run = 0, last_gap = -1;
  always @(negedge clock) if (chk_on) begin
    chk("mem_read", mem_read, reset && (owner == 0 ? i_read : owner == 1 && d_read));
    chk("mem_write", mem_write, reset && (owner == 0 ? i_write : owner == 1 && d_write));
    chk("mem_address", mem_address, owner == 0 ? i_address : owner == 1 ? d_address : 28'h0);
    chk("mem_writedata", mem_writedata, owner == 0 ? i_writedata : owner == 1 ? d_writedata : 128'h0);
    chk("i_busywait", i_busywait, ri && !(reset && owner == 0 && done));
    chk("d_busywait", d_busywait, rd && !(reset && owner == 1 && done));
    chk("i_readdata", i_readdata, mem_rdata_r);
    chk("d_readdata", d_readdata, mem_rdata_r);
    chk("i_rw_illegal", i_read & i_write, 1'b0);
    chk("d_rw_illegal", d_read & d_write, 1'b0);
    if (owner >= 0 && reset && done) chk("done_type", mem_read_done, mem_read);
    if (done && ri && !i_busywait) served.push_back(0);
    if (done && rd && !d_busywait) served.push_back(1);
    if (mem_read | mem_write) begin
      if (!seen_hi) first_wr = mem_write;
      if (seen_hi && !prev_hi) last_gap = gap_run;
      gap_run = 0;
      seen_hi = 1;
    end else if (seen_hi) gap_run++;
    prev_hi = mem_read | mem_write;
  end

  task automatic port_txn(input bit p, input bit wr, input logic [27:0] a);
    int n;
    n = 0;
    if (p) begin d_read = !wr; d_write = wr; d_address = a; d_writedata = {4{4'h5, a}}; end
    else begin i_read = !wr; i_write = wr; i_address = a; i_writedata = {4{4'h6, a}}; end
    @(negedge clock);
    while ((p ? d_busywait : i_busywait) && n < 2000) begin @(negedge clock); n++; end
    if (n >= 2000) begin
      asserts++;
      fails++;
      $display("FAIL txn_timeout port=%0d addr=%0h", p, a);
    end else if (!wr) chk(p ? "txn_d_readdata" : "txn_i_readdata", p ? d_readdata : i_readdata, {4{4'hA, a}});
    @(posedge clock); #1;
    if (p) begin d_read = 0; d_write = 0; end
    else begin i_read = 0; i_write = 0; end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, base, cnt;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_mem_writedata", mem_writedata, 0);
    chk("rst_i_busy", i_busywait, 0);
    chk("rst_d_busy", d_busywait, 0);
    chk_on = 1;
    reset = 1;
    // single D read
    @(posedge clock); #1;
    d_read = 1;
    d_address = 28'h10;
    #1;
    chk("t1_busy_now", d_busywait, 1);
    chk("t1_mem_idle", mem_read, 0);
    @(posedge clock); #2;
    chk("t1_mem_read", mem_read, 1);
    chk("t1_mem_addr", mem_address, 28'h10);
    n = 0;
    while (d_busywait && n < 20) begin @(posedge clock); #2; n++; end
    chk("t1_latency", n, 5);
    chk("t1_readdata", d_readdata, 128'hA0000010_A0000010_A0000010_A0000010);
    @(posedge clock); #1;
    d_read = 0;
    #1;
    chk("t1_idle_after", mem_read, 0);
    chk("t1_busy_after", d_busywait, 0);
    // simultaneous I read / D write, twice
    @(posedge clock); #1;
    for (int r = 0; r < 2; r++) begin
      seen_hi = 0;
      prev_hi = 0;
      last_gap = -1;
      base = served.size();
      fork
        port_txn(0, 0, 28'h20);
        port_txn(1, 1, 28'h40);
      join
      chk("pair_first_is_write", first_wr, RR ? 0 : 1);
      chk("pair_gap", last_gap, 1);
      chk("pair_first_port", served[base], RR ? 0 : 1);
      chk("pair_second_port", served[base+1], RR ? 1 : 0);
    end
    // reset two cycles into an I grant
    i_read = 1;
    i_address = 28'h80;
    @(posedge clock);
    @(posedge clock); #1;
    reset = 0;
    #1;
    chk("rst_mid_mem_read", mem_read, 0);
    chk("rst_mid_i_busy", i_busywait, 1);
    @(posedge clock); #1;
    reset = 1;
    stray_rd = 1;
    #1;
    chk("rst_stray_i_busy", i_busywait, 1);
    chk("rst_stray_mem_read", mem_read, 0);
    @(posedge clock); #1;
    stray_rd = 0;
    base = served.size();
    port_txn(0, 0, 28'h80);
    chk("rst_retry_served", served.size() - base, 1);
    // spurious done with nothing pending
    @(posedge clock); #1;
    stray_rd = 1;
    stray_wr = 1;
    #1;
    chk("stray_i_busy", i_busywait, 0);
    chk("stray_d_busy", d_busywait, 0);
    chk("stray_mem_read", mem_read, 0);
    chk("stray_mem_address", mem_address, 0);
    @(posedge clock); #1;
    stray_rd = 0;
    stray_wr = 0;
    #1;
    chk("stray_after_mem_write", mem_write, 0);
    // continuous D traffic with I pending
    @(posedge clock); #1;
    base = served.size();
    fork
      repeat (50) port_txn(1, 0, 28'h44);
      port_txn(0, 0, 28'h24);
    join
    cnt = 0;
    for (int k = base; k < served.size() && served[k] == 1; k++) cnt++;
    if (RR) chk("rr_i_served_soon", cnt <= 2, 1);
    else chk("fixed_i_starved", cnt, 50);
    repeat (3) @(posedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single block-wide data memory between two cache-miss requesters.
- Port I is the instruction cache refill; port D is the data cache refill/write-back.
- Sits between both caches and the memory. It sequences one memory transaction at a time and drives each cache's busywait.
- The memory-side interface is identical to the existing cache-to-memory interface, so the memory module is reused unchanged.

Parameters:
- c_block_size, 2, log2 of words per cache line
- c_line_size, 32, bits per word
- address_size, 32, byte-address width
- LINE_W, 2**c_block_size*c_line_size (128), block data width (derived, not overridden)
- ADDR_W, address_size-c_block_size-2 (28), block address width (derived)

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-low reset
- i_read  in  1  port I block read request, held until its busywait is low
- i_write  in  1  port I block write request, held until its busywait is low
- i_address  in  ADDR_W  port I block address
- i_writedata  in  LINE_W  port I write block
- i_busywait  out  1  port I stall
- i_readdata  out  LINE_W  read block returned to port I
- d_read / d_write / d_address / d_writedata  in  1/1/ADDR_W/LINE_W  port D equivalents
- d_busywait  out  1  port D stall
- d_readdata  out  LINE_W  read block returned to port D
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_address  out  ADDR_W  memory block address
- mem_writedata  out  LINE_W  memory write block
- mem_busywait  in  1  memory busy (informational only, not used for sequencing)
- mem_readdata  in  LINE_W  memory read block
- mem_read_done  in  1  single-cycle read-complete pulse
- mem_write_done  in  1  single-cycle write-complete pulse

Behaviour:
- Definitions: req_x = x_read | x_write; done = mem_read_done | mem_write_done.
- State machine: IDLE, GNT_I, GNT_D (state register plus a last_grant bit).
- IDLE:
  - mem_read = mem_write = 0; mem_address and mem_writedata = 0.
  - If req_I or req_D, pick a winner (see priority) and enter GNT_I or GNT_D on the next edge.
  - Memory therefore sees a request 1 cycle after the cache raises it.
- GNT_x:
  - mem_read/mem_write/mem_address/mem_writedata are combinationally forwarded from port x.
  - The other port's request is held off.
  - On done, next state is IDLE and last_grant <= x.
- busywait_x = req_x & ~(state==GNT_x & done), purely combinational.
  - The granted cache sees busywait low in exactly the done cycle and must drop its request at the following edge.
  - A losing or waiting requester sees busywait high continuously.
- i_readdata = d_readdata = mem_readdata (broadcast); the data is valid for the granted port only in its done cycle.
- Minimum gap is 1 IDLE cycle between transactions. A pending loser is granted from that IDLE cycle, giving back-to-back service with a 1-cycle bubble.
- Priority without the optional feature: fixed, D beats I, because a load miss stalls the MEM stage.
- done while in IDLE is ignored.
- done for the wrong type is still accepted as completion; the bench flags it.
- x_read & x_write both high is illegal; signals are forwarded as-is and the bench asserts it never occurs.
- A request withdrawn while in GNT_x (protocol violation) does not abort; the arbiter waits for done.
- Reset:
  - While reset==0, mem_read/mem_write are gated to 0 combinationally.
  - At the edge, state <= IDLE and last_grant <= D.
  - Reset mid-transaction abandons it; memory is reset in the same cycle.
- Reset values: mem_read 0, mem_write 0, mem_address 0, mem_writedata 0, readdata = mem_readdata.
  - i_busywait/d_busywait follow req_x (no grant, so no done path).

Optional Feature:
- Macro: DMEM_ARB_ROUND_ROBIN_EN.
- Defined: when both ports request in IDLE, grant the port != last_grant; a single request is granted directly.
- Undefined: fixed D>I priority. last_grant is still maintained but unused, and I may starve under continuous D traffic.

Decomposition:
- Package dmem_arb_pkg holds:
  - state enum {IDLE, GNT_I, GNT_D}
  - port index constants PORT_I=0, PORT_D=1
  - LINE_W/ADDR_W derivation functions
- One sub-module, dmem_arb_pick: combinational winner selection from (req_I, req_D, last_grant).
  - It contains the DMEM_ARB_ROUND_ROBIN_EN conditional, keeping the FSM free of it.

Test Plan:
- Single D read at addr 0x0000010: d_busywait high at once; mem_read rises 1 cycle later with mem_address=0x0000010; memory done after 5 cycles → d_readdata = memory block in the done cycle, d_busywait low that cycle, state IDLE next.
- Simultaneous I read 0x20 and D write 0x40 from IDLE, fixed priority: D granted first with mem_write=1; after mem_write_done, 1 IDLE cycle, then I granted; i_busywait high throughout D service.
- Same stimulus with DMEM_ARB_ROUND_ROBIN_EN and last_grant=D after reset: I granted first, then D; a repeated simultaneous pair alternates grants.
- reset=0 asserted 2 cycles into a GNT_I read: mem_read=0 in the reset cycle, state IDLE after the edge, a stray mem_read_done next cycle ignored, no busywait release.
- Continuous D requests with I pending, macro off: I never granted over 50 transactions (starvation is documented). Macro on: I served within 2 transactions.
- Spurious mem_read_done in IDLE with no requests: no output changes, both busywaits stay 0.
